// File: rtl/input_buffer_pkg.sv
// Shared constants and FSM state type for the input staging buffer.
package input_buffer_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/input_buffer_if.sv
// Host write port, burst command and array-side valid/ready stream.
interface input_buffer_if;
  import input_buffer_pkg::*;

  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] ip_buf_addr_for_store;
  logic              ip_buffer_instr_for_storing_data;
  logic [ADDR_W-1:0] ip_buf_addr_for_burst;
  logic [LEN_W-1:0]  burst_len;
  logic              ip_buffer_instr_for_sending_data;
  logic [DATA_W-1:0] arr_data;
  logic              arr_valid;
  logic              arr_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  data, ip_buf_addr_for_store, ip_buffer_instr_for_storing_data,
           ip_buf_addr_for_burst, burst_len, ip_buffer_instr_for_sending_data,
           arr_ready,
    output arr_data, arr_valid, busy, done, err
  );

  modport master (
    output data, ip_buf_addr_for_store, ip_buffer_instr_for_storing_data,
           ip_buf_addr_for_burst, burst_len, ip_buffer_instr_for_sending_data,
           arr_ready,
    input  arr_data, arr_valid, busy, done, err
  );
endinterface

// File: rtl/ip_buf_mem.sv
// Operand register file: synchronous write and clear, combinational read.
module ip_buf_mem
  import input_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/input_buffer.sv
// Addressed input staging buffer with burst sequencer toward the array feeders.
// Define IP_BUF_WRAP_EN to let bursts wrap modulo DEPTH instead of rejecting them.
//
// state | meaning
// IDLE  | waiting for a start strobe
// SEND  | streaming words, arr_valid high
// DONE  | done pulse, back to IDLE next cycle
module input_buffer
  import input_buffer_pkg::*;
(
  input logic           clk,
  input logic           rst,
  input_buffer_if.slave bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] arr_data_q;
  logic              arr_valid_q;
  logic              err_q;
  logic              load_first, load_next, finish, reject;
  logic              len_bad, ovf, beat;

  ip_buf_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.ip_buffer_instr_for_storing_data),
    .wr_addr (bus.ip_buf_addr_for_store),
    .wr_data (bus.data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign beat    = arr_valid_q & bus.arr_ready;
  assign len_bad = bus.burst_len > LEN_W'(DEPTH);

`ifdef IP_BUF_WRAP_EN
  assign ovf = 1'b0;
`else
  logic [LEN_W:0] end_addr;
  assign end_addr = (LEN_W+1)'(bus.ip_buf_addr_for_burst) + (LEN_W+1)'(bus.burst_len);
  assign ovf      = end_addr > (LEN_W+1)'(DEPTH);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    finish     = 1'b0;
    reject     = 1'b0;
    rd_addr    = addr_q;
    unique case (state)
      IDLE: begin
        rd_addr = bus.ip_buf_addr_for_burst;
        if (bus.ip_buffer_instr_for_sending_data) begin
          if (len_bad || ovf) begin
            reject = 1'b1;
          end else if (bus.burst_len == '0) begin
            state_nxt = DONE;
          end else begin
            load_first = 1'b1;
            state_nxt  = SEND;
          end
        end
      end
      SEND: begin
        if (beat) begin
          if (remaining > LEN_W'(1)) begin
            load_next = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // addr_q always points at the word to load on the next accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_data_q  <= '0;
      arr_valid_q <= 1'b0;
      addr_q      <= '0;
      remaining   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= reject;
      if (load_first) begin
        arr_data_q  <= rd_data;
        arr_valid_q <= 1'b1;
        addr_q      <= bus.ip_buf_addr_for_burst + ADDR_W'(1);
        remaining   <= bus.burst_len;
      end else if (load_next) begin
        arr_data_q <= rd_data;
        addr_q     <= addr_q + ADDR_W'(1);
        remaining  <= remaining - LEN_W'(1);
      end else if (finish) begin
        arr_valid_q <= 1'b0;
      end
    end
  end

  assign bus.arr_data  = arr_data_q;
  assign bus.arr_valid = arr_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: vector table of bursts plus hand-written
// sequences for busy-start, collision, write latency and mid-burst reset.
module tb_input_buffer;
  import input_buffer_pkg::*;

`ifdef IP_BUF_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_buffer_if bus ();

  input_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  s;
    logic [4:0]  n;
    logic [15:0] rdy;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] model_mem [16];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ip_buffer_instr_for_storing_data = 1'b1;
    bus.ip_buf_addr_for_store = a;
    bus.data = d;
    model_mem[a] = d;
  endtask

  task automatic pop_chk(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s extra beat actual %h required none", name, bus.arr_data);
    end else begin
      e = exp_q.pop_front();
      chk(name, bus.arr_data, e);
    end
  endtask

  // Observe each cycle at negedge; ready driven here applies to the next posedge.
  task automatic drain(input logic [15:0] rdy, input int n);
    int cyc = 0;
    int idx = 0;
    int beats = 0;
    bit held = 1'b0;
    bit fin = 1'b0;
    logic [31:0] hd = '0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("first_valid", {31'd0, bus.arr_valid}, {31'd0, n > 0});
        chk("first_busy", {31'd0, bus.busy}, 32'd1);
        chk("first_err", {31'd0, bus.err}, 32'd0);
      end
      if (held) begin
        chk("hold_valid", {31'd0, bus.arr_valid}, 32'd1);
        chk("hold_data", bus.arr_data, hd);
      end
      if (bus.done) begin
        chk("done_valid", {31'd0, bus.arr_valid}, 32'd0);
        fin = 1'b1;
      end else if (cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual %0d cycles required done", cyc);
        fin = 1'b1;
      end else if (bus.arr_valid) begin
        bus.arr_ready = rdy[idx % 16];
        idx++;
        if (bus.arr_ready) begin
          beats++;
          pop_chk("beat_data");
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = bus.arr_data;
        end
      end
    end
    chk("beat_count", beats, n);
    chk("queue_empty", exp_q.size(), 0);
    if (rdy == 16'hFFFF) chk("burst_cycles", cyc, n + 1);
    bus.arr_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.done}, 32'd0);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic run_burst(input logic [3:0] s, input logic [4:0] n,
                           input logic [15:0] rdy, input bit exp_err);
    logic [3:0] a;
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        a = s + 4'(i);
        exp_q.push_back(model_mem[a]);
      end
    end
    @(negedge clk);
    bus.ip_buffer_instr_for_storing_data = 1'b0;
    bus.ip_buffer_instr_for_sending_data = 1'b1;
    bus.ip_buf_addr_for_burst = s;
    bus.burst_len = n;
    if (exp_err) begin
      @(negedge clk);
      bus.ip_buffer_instr_for_sending_data = 1'b0;
      chk("err_pulse", {31'd0, bus.err}, 32'd1);
      chk("err_valid", {31'd0, bus.arr_valid}, 32'd0);
      chk("err_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk("err_single", {31'd0, bus.err}, 32'd0);
      chk("err_no_beat", {31'd0, bus.arr_valid}, 32'd0);
    end else begin
      @(negedge clk);
      bus.ip_buffer_instr_for_sending_data = 1'b0;
      // first observed cycle is consumed here, so check it before draining the rest
      chk("first_valid", {31'd0, bus.arr_valid}, {31'd0, n > 0});
      chk("first_err", {31'd0, bus.err}, 32'd0);
      if (n == 0) begin
        chk("len0_done", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        chk("len0_done_pulse", {31'd0, bus.done}, 32'd0);
        chk("len0_busy", {31'd0, bus.busy}, 32'd0);
      end else begin
        bus.arr_ready = rdy[0];
        if (rdy[0]) pop_chk("beat_data");
        drain({1'b1, rdy[15:1]}, (rdy[0] ? int'(n) - 1 : int'(n)));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.data = '0;
    bus.ip_buf_addr_for_store = '0;
    bus.ip_buffer_instr_for_storing_data = 1'b0;
    bus.ip_buf_addr_for_burst = '0;
    bus.burst_len = '0;
    bus.ip_buffer_instr_for_sending_data = 1'b0;
    bus.arr_ready = 1'b1;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    // reset held for two edges
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_arr_data", bus.arr_data, 32'd0);
    chk("rst_arr_valid", {31'd0, bus.arr_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    run_burst(4'd0, 5'd1, 16'hFFFF, 1'b0);

    for (int i = 0; i < 16; i++) do_write(4'(i), 32'hC000_0000 + i);
    for (int i = 0; i < 4; i++) do_write(4'(i), 32'hA0 + i);

    vecs[0] = '{s: 4'd0,  n: 5'd4,  rdy: 16'hFFFF, exp_err: 1'b0};
    vecs[1] = '{s: 4'd0,  n: 5'd4,  rdy: 16'hFFD9, exp_err: 1'b0};
    vecs[2] = '{s: 4'd0,  n: 5'd0,  rdy: 16'hFFFF, exp_err: 1'b0};
    vecs[3] = '{s: 4'd0,  n: 5'd17, rdy: 16'hFFFF, exp_err: 1'b1};
    vecs[4] = '{s: 4'd0,  n: 5'd16, rdy: 16'hFFFF, exp_err: 1'b0};
    vecs[5] = '{s: 4'd12, n: 5'd4,  rdy: 16'hAAAA, exp_err: 1'b0};
    vecs[6] = '{s: 4'd13, n: 5'd4,  rdy: 16'hFFFF, exp_err: !WRAP};
    for (int v = 0; v < 7; v++) run_burst(vecs[v].s, vecs[v].n, vecs[v].rdy, vecs[v].exp_err);

    // wrap window 14,15,0,1
    do_write(4'd14, 32'hE);
    do_write(4'd15, 32'hF);
    do_write(4'd0, 32'h10);
    do_write(4'd1, 32'h11);
    run_burst(4'd14, 5'd4, 16'hFFFF, !WRAP);

    // start while busy is ignored; would be rejected if it were seen
    for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[i]);
    @(negedge clk);
    bus.ip_buffer_instr_for_storing_data = 1'b0;
    bus.arr_ready = 1'b0;
    bus.ip_buffer_instr_for_sending_data = 1'b1;
    bus.ip_buf_addr_for_burst = 4'd0;
    bus.burst_len = 5'd4;
    @(negedge clk);
    chk("busy_hold_valid", {31'd0, bus.arr_valid}, 32'd1);
    bus.ip_buf_addr_for_burst = 4'd8;
    bus.burst_len = 5'd17;
    @(negedge clk);
    bus.ip_buffer_instr_for_sending_data = 1'b0;
    chk("busy_start_err", {31'd0, bus.err}, 32'd0);
    chk("busy_start_busy", {31'd0, bus.busy}, 32'd1);
    chk("busy_start_data", bus.arr_data, model_mem[0]);
    drain(16'hFFFF, 4);

    // write lands on the same edge word 2 is loaded: old value goes out
    for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[i]);
    @(negedge clk);
    bus.arr_ready = 1'b1;
    bus.ip_buffer_instr_for_sending_data = 1'b1;
    bus.ip_buf_addr_for_burst = 4'd0;
    bus.burst_len = 5'd4;
    @(negedge clk);
    bus.ip_buffer_instr_for_sending_data = 1'b0;
    chk("coll_v0", {31'd0, bus.arr_valid}, 32'd1);
    pop_chk("coll_w0");
    @(negedge clk);
    pop_chk("coll_w1");
    bus.ip_buffer_instr_for_storing_data = 1'b1;
    bus.ip_buf_addr_for_store = 4'd2;
    bus.data = 32'hBB;
    @(negedge clk);
    bus.ip_buffer_instr_for_storing_data = 1'b0;
    pop_chk("coll_w2_old");
    @(negedge clk);
    pop_chk("coll_w3");
    @(negedge clk);
    chk("coll_done", {31'd0, bus.done}, 32'd1);
    chk("coll_valid_low", {31'd0, bus.arr_valid}, 32'd0);
    model_mem[2] = 32'hBB;
    run_burst(4'd2, 5'd1, 16'hFFFF, 1'b0);

    // write at edge k, start at edge k+1
    do_write(4'd5, 32'h55);
    run_burst(4'd5, 5'd1, 16'hFFFF, 1'b0);

    // reset mid-burst
    @(negedge clk);
    bus.arr_ready = 1'b1;
    bus.ip_buffer_instr_for_sending_data = 1'b1;
    bus.ip_buf_addr_for_burst = 4'd0;
    bus.burst_len = 5'd4;
    @(negedge clk);
    bus.ip_buffer_instr_for_sending_data = 1'b0;
    chk("abort_pre_valid", {31'd0, bus.arr_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", {31'd0, bus.arr_valid}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_data", bus.arr_data, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    exp_q.delete();
    run_burst(4'd3, 5'd1, 16'hFFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
